// File: rtl/counter_nbit_pkg.sv
// Shared counter definitions: boundary-mode constants reused by the counter family.
package counter_nbit_pkg;

  typedef enum logic {
    COUNT_WRAP = 1'b0,
    COUNT_SAT  = 1'b1
  } count_mode_e;

  localparam int unsigned COUNT_MIN_WIDTH = 2;
  localparam int unsigned COUNT_MAX_WIDTH = 32;

  // Largest legal terminal count for a given width, computed in 64 bits so WIDTH=32 does not overflow.
  function automatic logic [63:0] count_limit(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_nbit_if.sv
// Control/status bundle of the counter; master drives controls, slave is the counter.
interface counter_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D_IN;
  logic [WIDTH-1:0] Q_OUT;
  logic             TC;
  logic             OVF;

  modport master (
    output EN, UP, LD, D_IN,
    input  Q_OUT, TC, OVF
  );

  modport slave (
    input  EN, UP, LD, D_IN,
    output Q_OUT, TC, OVF
  );
endinterface

// File: rtl/counter_nbit.sv
// Up/down counter bounded to 0..MAX with load, wrap-or-saturate boundary handling and
// a registered boundary-event pulse.
module counter_nbit
  import counter_nbit_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [31:0] MAX      = 32'(count_limit(WIDTH)),
  parameter bit          SATURATE = COUNT_WRAP
) (
  input  logic           CLK,
  input  logic           CLR,
  counter_nbit_if.slave  bus
);

  localparam logic [63:0]      MAX_LIMIT = count_limit(WIDTH);
  localparam logic [WIDTH-1:0] MAX_W     = MAX[WIDTH-1:0];
  localparam bit               SAT_MODE  = (SATURATE == COUNT_SAT);

  if (WIDTH < COUNT_MIN_WIDTH || WIDTH > COUNT_MAX_WIDTH) begin : g_bad_width
    $error("counter_nbit: WIDTH must lie in 2..32");
  end

  if (MAX == 32'd0 || 64'(MAX) > MAX_LIMIT) begin : g_bad_max
    $error("counter_nbit: MAX must lie in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] q_q = '0;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q = 1'b0;
  logic             ovf_d;
  logic             tc;

  assign tc = bus.UP ? (q_q == MAX_W) : (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (CLR) begin
      q_d = '0;
    end else if (bus.LD) begin
      q_d = (bus.D_IN > MAX_W) ? MAX_W : bus.D_IN;
    end else if (bus.EN) begin
      // A counting step at a bound is the boundary event, whether it wraps or is blocked.
      ovf_d = tc;
      if (bus.UP) begin
        if (q_q == MAX_W) q_d = SAT_MODE ? MAX_W : '0;
        else              q_d = q_q + WIDTH'(1);
      end else begin
        if (q_q == '0)    q_d = SAT_MODE ? '0 : MAX_W;
        else              q_d = q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    q_q   <= q_d;
    ovf_q <= ovf_d;
  end

  assign bus.Q_OUT = q_q;
  assign bus.TC    = tc;
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_counter_nbit.sv
// Drives three counter configurations (MAX=9 wrap, MAX=9 saturate, default) with shared
// stimulus and compares them against an arithmetic reference model.
module tb_counter_nbit;

  logic       CLK = 1'b0;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [7:0] din = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  counter_nbit_if #(.WIDTH(8)) if_w ();
  counter_nbit_if #(.WIDTH(8)) if_s ();
  counter_nbit_if #(.WIDTH(8)) if_d ();

  assign if_w.EN = en;  assign if_w.UP = up;  assign if_w.LD = ld;  assign if_w.D_IN = din;
  assign if_s.EN = en;  assign if_s.UP = up;  assign if_s.LD = ld;  assign if_s.D_IN = din;
  assign if_d.EN = en;  assign if_d.UP = up;  assign if_d.LD = ld;  assign if_d.D_IN = din;

  counter_nbit #(.WIDTH(8), .MAX(32'd9), .SATURATE(1'b0)) dut_w (.CLK(CLK), .CLR(clr), .bus(if_w));
  counter_nbit #(.WIDTH(8), .MAX(32'd9), .SATURATE(1'b1)) dut_s (.CLK(CLK), .CLR(clr), .bus(if_s));
  counter_nbit #(.WIDTH(8))                               dut_d (.CLK(CLK), .CLR(clr), .bus(if_d));

  logic [7:0] q_obs  [3];
  logic       tc_obs [3];
  logic       ovf_obs[3];
  assign q_obs[0] = if_w.Q_OUT;  assign tc_obs[0] = if_w.TC;  assign ovf_obs[0] = if_w.OVF;
  assign q_obs[1] = if_s.Q_OUT;  assign tc_obs[1] = if_s.TC;  assign ovf_obs[1] = if_s.OVF;
  assign q_obs[2] = if_d.Q_OUT;  assign tc_obs[2] = if_d.TC;  assign ovf_obs[2] = if_d.OVF;

  // Reference model state per configuration.
  int mx [3] = '{9, 9, 255};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int mq [3] = '{0, 0, 0};
  int mo [3] = '{0, 0, 0};
  int ovf_pulses_d;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check TC before the edge, update model, check Q/OVF after it.
  task automatic step(input bit c, input bit e, input bit u, input bit l, input int d);
    int t;
    clr = c; en = e; up = u; ld = l; din = 8'(d);
    #1;
    for (int k = 0; k < 3; k++) begin
      t = u ? int'(mq[k] == mx[k]) : int'(mq[k] == 0);
      check($sformatf("tc[%0d]", k), int'(tc_obs[k]), t);
      if (c) begin
        mq[k] = 0; mo[k] = 0;
      end else if (l) begin
        mq[k] = (d > mx[k]) ? mx[k] : d; mo[k] = 0;
      end else if (e) begin
        mo[k] = t;
        if (u) mq[k] = sat[k] ? ((mq[k] + 1 > mx[k]) ? mx[k] : mq[k] + 1) : (mq[k] + 1) % (mx[k] + 1);
        else   mq[k] = sat[k] ? ((mq[k] - 1 < 0) ? 0 : mq[k] - 1) : (mq[k] + mx[k]) % (mx[k] + 1);
      end else begin
        mo[k] = 0;
      end
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("q[%0d]", k), int'(q_obs[k]), mq[k]);
      check($sformatf("ovf[%0d]", k), int'(ovf_obs[k]), mo[k]);
    end
    ovf_pulses_d += int'(ovf_obs[2]);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // Power-up state before any CLR.
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pwrup_q[%0d]", k), int'(q_obs[k]), 0);
      check($sformatf("pwrup_ovf[%0d]", k), int'(ovf_obs[k]), 0);
    end
    @(posedge CLK); #1;

    // Clear, then 12 up edges: wrap 9->0 with a single OVF pulse.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 0, 0);
      check("seq_q", int'(if_w.Q_OUT), exp_seq[i]);
      check("seq_ovf", int'(if_w.OVF), (i == 9) ? 1 : 0);
    end

    // Saturating counter blocked at 0 going down: holds, TC high, OVF every edge.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      check("sat_q", int'(if_s.Q_OUT), 0);
      check("sat_tc", int'(if_s.TC), 1);
      check("sat_ovf", int'(if_s.OVF), 1);
    end

    // Load above MAX is clamped and wins over EN.
    step(0, 1, 1, 1, 200);
    check("ld_clamp_q", int'(if_w.Q_OUT), 9);
    check("ld_clamp_ovf", int'(if_w.OVF), 0);
    check("ld_def_q", int'(if_d.Q_OUT), 200);

    // CLR beats LD and EN on the same edge.
    step(0, 0, 1, 1, 5);
    check("ld5_q", int'(if_w.Q_OUT), 5);
    step(1, 1, 1, 1, 7);
    check("clr_pri_q", int'(if_w.Q_OUT), 0);
    check("clr_pri_ovf", int'(if_w.OVF), 0);

    // Wrap downward from 0, then flip direction immediately.
    step(0, 1, 0, 0, 0);
    check("dn_wrap_q", int'(if_w.Q_OUT), 9);
    check("dn_wrap_ovf", int'(if_w.OVF), 1);
    step(0, 1, 1, 0, 0);
    check("dir_flip_q", int'(if_w.Q_OUT), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0, 1'($urandom),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 255)));
    end

    // Default configuration: 256 up edges from 0 return to 0 with one OVF pulse.
    step(1, 0, 1, 0, 0);
    ovf_pulses_d = 0;
    for (int i = 0; i < 256; i++) step(0, 1, 1, 0, 0);
    check("full_lap_q", int'(if_d.Q_OUT), 0);
    check("full_lap_ovf_count", ovf_pulses_d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_nbit.md
COUNTER_NBIT -- requirements
Module: counter_nbit

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 Port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 Port CLR  input  1  reset; synchronous, active-high.
REQ-006 Port EN  input  1  count enable.
REQ-007 Port UP  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Port LD  input  1  parallel load strobe.
REQ-009 Port D_IN  input  WIDTH  load value.
REQ-010 Port Q_OUT  output  WIDTH  registered count.
REQ-011 Port TC  output  1  combinational terminal-count flag.
REQ-012 Port OVF  output  1  registered one-cycle boundary-event pulse.

Function
REQ-013 Q_OUT SHALL always lie in 0..MAX.
REQ-014 Priority per rising edge SHALL be CLR > LD > EN; lower-priority inputs are ignored that cycle.
REQ-015 LD=1 SHALL load D_IN, clamped to MAX if D_IN > MAX; Q_OUT updates at the same edge (1-cycle latency).
REQ-016 EN=1, LD=0, UP=1, Q_OUT<MAX SHALL yield Q_OUT+1.
REQ-017 EN=1, LD=0, UP=0, Q_OUT>0 SHALL yield Q_OUT-1.
REQ-018 Up at Q_OUT=MAX: SATURATE=0 -> Q_OUT=0; SATURATE=1 -> Q_OUT holds MAX.
REQ-019 Down at Q_OUT=0: SATURATE=0 -> Q_OUT=MAX; SATURATE=1 -> Q_OUT holds 0.
REQ-020 EN=0, LD=0, CLR=0 SHALL hold Q_OUT.
REQ-021 TC SHALL be 1 iff (UP=1 and Q_OUT=MAX) or (UP=0 and Q_OUT=0), independent of EN.
REQ-022 OVF SHALL be 1 for exactly the cycle after an edge at which EN=1, LD=0, CLR=0 and TC=1; otherwise 0.
REQ-023 OVF SHALL pulse in both SATURATE modes (wrap or blocked step).
REQ-024 Arithmetic SHALL be unsigned, WIDTH bits; no intermediate value outside 0..MAX is ever registered.
REQ-025 UP changes SHALL take effect at the next counting edge with no extra latency.

Reset
REQ-026 CLR=1 at a rising edge SHALL set Q_OUT=0 and OVF=0, regardless of EN, LD, UP.
REQ-027 CLR asserted mid-count SHALL discard the pending step; counting resumes from 0 on the first edge with CLR=0 and EN=1.
REQ-028 Power-up (before any CLR) Q_OUT and OVF SHALL initialise to 0.
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 Mode constants (COUNT_WRAP=0, COUNT_SAT=1) SHALL live in the shared com package/header, reused by future counters.
REQ-031 Next-value logic SHALL be inline; no sub-module.
REQ-032 Exactly WIDTH+1 flip-flops (Q_OUT, OVF) SHALL be inferred.
REQ-033 Elaboration SHALL fail if MAX is 0 or exceeds 2**WIDTH-1.

Verification (WIDTH=8, MAX=9 unless stated)
REQ-034 CLR=1 one edge, then EN=1 UP=1 for 12 edges -> Q_OUT 1..9,0,1,2; OVF=1 only in the cycle after 9->0.
REQ-035 SATURATE=1, Q_OUT=0, EN=1 UP=0 for 3 edges -> Q_OUT stays 0, TC=1, OVF pulses each edge.
REQ-036 LD=1 D_IN=200 with EN=1 -> Q_OUT=9 (clamped), no increment, OVF=0.
REQ-037 Q_OUT=5, CLR=1 LD=1 EN=1 same edge -> Q_OUT=0, OVF=0.
REQ-038 Q_OUT=0, UP=0 EN=1 SATURATE=0 -> Q_OUT=9, OVF=1 next cycle; toggle UP=1 next edge -> Q_OUT=0.
REQ-039 Default parameters (MAX=255), 256 up edges from 0 -> Q_OUT=0, single OVF pulse.
